// File: rtl/pipelined_addsub.sv
// pipelined_addsub: two's-complement adder/subtractor split into STAGES equal
// chunks of C = WIDTH/STAGES bits. Each pipeline stage resolves one chunk and
// hands its carry to the next stage. All stages advance together under a
// global enable driven by output backpressure.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready = global advance enable)
//   a, b                 WIDTH-bit operands
//   cin                  carry-in (add) / borrow-in (subtract)
//   sub                  0: a+b+cin, 1: a-b-cin
//   out_valid/out_ready  output handshake
//   sum                  WIDTH-bit result, modulo 2^WIDTH
//   cout                 raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf                  signed overflow
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: STAGES must lie in 1..WIDTH and divide WIDTH");
  end

  localparam int C = WIDTH / STAGES;

  function automatic logic [C:0] chunk_add(input logic [C-1:0] x,
                                           input logic [C-1:0] y,
                                           input logic         ci);
    return {1'b0, x} + {1'b0, y} + {{C{1'b0}}, ci};
  endfunction

  logic             en;
  logic             accept;
  logic [WIDTH-1:0] b_x;
  logic             c0;

  // Whole pipeline moves only when the output slot is empty or being drained.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Subtract is a + ~b + ~cin, so borrow-in becomes an inverted carry-in.
  assign b_x = sub ? ~b : b;
  assign c0  = sub ^ cin;

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    // Operand bits not yet resolved when entering this stage (chunk s-1 at bit 0).
    localparam int WA = WIDTH - (s - 1) * C;

    logic [WA-1:0]  a_src;
    logic [WA-1:0]  bx_src;
    logic           cy_src;
    logic           vld_src;
    logic [C:0]     ch;
    logic [s*C-1:0] res_nxt;

    assign ch = chunk_add(a_src[C-1:0], bx_src[C-1:0], cy_src);

    if (s == 1) begin : g_src
      assign a_src   = a;
      assign bx_src  = b_x;
      assign cy_src  = c0;
      assign vld_src = accept;
      assign res_nxt = ch[C-1:0];
    end else begin : g_src
      assign a_src   = g_stage[s-1].g_reg.a_p;
      assign bx_src  = g_stage[s-1].g_reg.bx_p;
      assign cy_src  = g_stage[s-1].g_reg.cy_p;
      assign vld_src = g_stage[s-1].g_reg.vld_p;
      assign res_nxt = {ch[C-1:0], g_stage[s-1].g_reg.res_p};
    end

    if (s < STAGES) begin : g_reg
      // ---- stage boundary: resolved low chunks, carry, remaining upper operands
      logic [s*C-1:0]  res_p;
      logic [WA-C-1:0] a_p;
      logic [WA-C-1:0] bx_p;
      logic            cy_p;
      logic            vld_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= 1'b0;
        end else if (en) begin
          vld_p <= vld_src;
        end
      end

      always_ff @(posedge clk) begin
        if (en && vld_src) begin
          res_p <= res_nxt;
          a_p   <= a_src[WA-1:C];
          bx_p  <= bx_src[WA-1:C];
          cy_p  <= ch[C];
        end
      end
    end else begin : g_out
      // ---- final stage boundary: registered outputs
      logic c_msb;

      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
      assign c_msb = a_src[C-1] ^ bx_src[C-1] ^ res_nxt[WIDTH-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (en) begin
          out_valid <= vld_src;
          if (vld_src) begin
            sum  <= res_nxt;
            cout <= ch[C];
            ovf  <= ch[C] ^ c_msb;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub: directed table on an 8-bit/4-stage instance,
// backpressure and mid-stream reset sequences, and randomized scoreboards on
// four further (WIDTH, STAGES) configurations.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit, 4-stage instance for directed tests
  logic       m_in_valid, m_in_ready, m_cin, m_sub;
  logic       m_out_valid, m_out_ready, m_cout, m_ovf;
  logic [7:0] m_a, m_b, m_sum;

  pipelined_addsub #(.WIDTH(8), .STAGES(4)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .a         (m_a),
    .b         (m_b),
    .cin       (m_cin),
    .sub       (m_sub),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .sum       (m_sum),
    .cout      (m_cout),
    .ovf       (m_ovf)
  );

  // Parameter sweep instances
  logic        sw_in_valid  [4];
  logic        sw_in_ready  [4];
  logic        sw_out_valid [4];
  logic        sw_cout      [4];
  logic        sw_ovf       [4];
  logic [63:0] sw_sum       [4];
  logic [63:0] sw_a, sw_b;
  logic        sw_cin, sw_sub, sw_out_ready;

  for (genvar k = 0; k < 4; k++) begin : g_sweep
    localparam int W = (k == 0) ? 8 : (k == 1) ? 8 : (k == 2) ? 32 : 64;
    localparam int S = (k == 0) ? 1 : (k == 1) ? 8 : (k == 2) ? 4 : 8;
    logic [W-1:0] sum_k;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_in_valid[k]),
      .in_ready  (sw_in_ready[k]),
      .a         (sw_a[W-1:0]),
      .b         (sw_b[W-1:0]),
      .cin       (sw_cin),
      .sub       (sw_sub),
      .out_valid (sw_out_valid[k]),
      .out_ready (sw_out_ready),
      .sum       (sum_k),
      .cout      (sw_cout[k]),
      .ovf       (sw_ovf[k])
    );
    assign sw_sum[k] = 64'(sum_k);
  end

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  // Reference: full-width a + b' + c0 in plain arithmetic, sign rule for overflow.
  function automatic res_t ref_op(input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub, input int w);
    res_t        r;
    logic [64:0] mask;
    logic [64:0] t;
    logic [63:0] bx;
    mask   = (65'd1 << w) - 65'd1;
    bx     = sub ? ~b : b;
    t      = ({1'b0, a} & mask) + ({1'b0, bx} & mask) + {64'd0, (sub ? ~cin : cin)};
    r.sum  = t[63:0] & mask[63:0];
    r.cout = t[w];
    r.ovf  = (a[w-1] == bx[w-1]) && (r.sum[w-1] != a[w-1]);
    r.cyc  = 0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Values sampled on the falling edge by m_step
  logic       m_acc, m_ret, m_ov_s, m_ir_s;
  logic [9:0] m_res_s;

  task automatic m_step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb, input logic ordy);
    m_in_valid  = iv;
    m_a         = a;
    m_b         = b;
    m_cin       = ci;
    m_sub       = sb;
    m_out_ready = ordy;
    @(negedge clk);
    m_acc   = m_in_valid && m_in_ready;
    m_ret   = m_out_valid && m_out_ready;
    m_ov_s  = m_out_valid;
    m_ir_s  = m_in_ready;
    m_res_s = {m_cout, m_ovf, m_sum};
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input int k, input int w, input int s);
    res_t        q[$];
    res_t        r;
    res_t        e;
    logic [63:0] a, b;
    logic        ci, sb, iv, ordy;
    for (int c = 0; c < 400; c++) begin
      iv   = (c < 380) && ($urandom_range(0, 3) != 0);
      ordy = (c < 150) || (c >= 380) || ($urandom_range(0, 2) != 0);
      a    = {$urandom(), $urandom()};
      b    = {$urandom(), $urandom()};
      ci   = 1'($urandom_range(0, 1));
      sb   = 1'($urandom_range(0, 1));
      sw_in_valid[k] = iv;
      sw_a           = a;
      sw_b           = b;
      sw_cin         = ci;
      sw_sub         = sb;
      sw_out_ready   = ordy;
      @(negedge clk);
      if (sw_out_valid[k] && sw_out_ready) begin
        if (q.size() == 0) begin
          chk($sformatf("sweep%0d_unexpected", k), 66'd1, 66'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("sweep%0d_result", k), {sw_cout[k], sw_ovf[k], sw_sum[k]},
              {e.cout, e.ovf, e.sum});
          if (c < 150) chk($sformatf("sweep%0d_latency", k), 66'(c - e.cyc), 66'(s));
        end
      end
      if (sw_in_valid[k] && sw_in_ready[k]) begin
        r     = ref_op(a, b, ci, sb, w);
        r.cyc = c;
        q.push_back(r);
      end
      @(posedge clk);
      #1;
    end
    sw_in_valid[k] = 1'b0;
    chk($sformatf("sweep%0d_drained", k), 66'(q.size()), 66'd0);
  endtask

  initial begin
    vec_t       tbl [9];
    res_t       mq[$];
    res_t       e;
    logic [7:0] op_a [8];
    logic [7:0] op_b [8];
    logic       op_c [8];
    logic       op_s [8];
    int         lat, sent, rcv, stalls, extra;
    logic       got, ordy, stalled_prev;
    logic [9:0] held;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[8] = '{8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};

    rst_n        = 1'b0;
    m_in_valid   = 1'b0;
    m_a          = '0;
    m_b          = '0;
    m_cin        = 1'b0;
    m_sub        = 1'b0;
    m_out_ready  = 1'b1;
    sw_a         = '0;
    sw_b         = '0;
    sw_cin       = 1'b0;
    sw_sub       = 1'b0;
    sw_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) sw_in_valid[k] = 1'b0;

    #22;
    chk("reset_outputs", 66'({m_out_valid, m_cout, m_ovf, m_sum}), 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 66'(m_in_ready), 66'd1);

    // Directed vectors, one at a time, with latency measurement
    for (int i = 0; i < 9; i++) begin
      m_step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1);
      chk($sformatf("vec%0d_accept", i), 66'(m_acc), 66'd1);
      got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20 && !got; c++) begin
        m_step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        if (m_ov_s) begin
          got = 1'b1;
          lat = c;
          chk($sformatf("vec%0d_result", i), 66'(m_res_s),
              66'({tbl[i].cout, tbl[i].ovf, tbl[i].sum}));
        end
      end
      chk($sformatf("vec%0d_latency", i), 66'(lat), 66'd4);
    end

    // Backpressure: 8 back-to-back operations, consumer stalls 3 cycles
    for (int i = 0; i < 8; i++) begin
      op_a[i] = 8'($urandom());
      op_b[i] = 8'($urandom());
      op_c[i] = 1'($urandom_range(0, 1));
      op_s[i] = 1'($urandom_range(0, 1));
    end
    sent = 0;
    rcv = 0;
    stalls = 0;
    stalled_prev = 1'b0;
    held = '0;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      ordy = !(c >= 6 && c < 9);
      if (sent < 8) m_step(1'b1, op_a[sent], op_b[sent], op_c[sent], op_s[sent], ordy);
      else          m_step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ordy);
      if (m_ret) begin
        if (mq.size() == 0) begin
          chk("bp_unexpected", 66'd1, 66'd0);
        end else begin
          e = mq.pop_front();
          chk($sformatf("bp_result%0d", rcv), 66'(m_res_s), 66'({e.cout, e.ovf, e.sum[7:0]}));
        end
        rcv++;
      end
      if (m_ov_s && !ordy) begin
        stalls++;
        chk("bp_in_ready_low", 66'(m_ir_s), 66'd0);
        if (stalled_prev) chk("bp_hold_stable", 66'(m_res_s), 66'(held));
        held = m_res_s;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (m_acc) begin
        mq.push_back(ref_op(64'(op_a[sent]), 64'(op_b[sent]), op_c[sent], op_s[sent], 8));
        sent++;
      end
    end
    chk("bp_stall_cycles", 66'(stalls), 66'd3);
    chk("bp_received", 66'(rcv), 66'd8);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      m_step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      if (m_ret) extra++;
    end
    chk("bp_no_duplicates", 66'(extra), 66'd0);

    // Reset with three operations in flight and the first one held at the output
    m_step(1'b1, 8'hC0, 8'h50, 1'b0, 1'b0, 1'b0);
    m_step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    m_step(1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      m_step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      got = m_ov_s;
    end
    chk("rst_pre_held", 66'(m_res_s), 66'({1'b1, 1'b0, 8'h10}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", 66'({m_out_valid, m_cout, m_ovf, m_sum}), 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 66'(m_in_ready), 66'd1);
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      m_step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      if (m_ov_s) extra++;
    end
    chk("rst_no_stale", 66'(extra), 66'd0);

    // Parameter sweep
    run_sweep(0, 8, 1);
    run_sweep(1, 8, 8);
    run_sweep(2, 32, 4);
    run_sweep(3, 64, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
